// File: rtl/skullfet_seq_pkg.sv
// Shared types and constants for the SKULLFET cell test sequencer.
package skullfet_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int ERR_W       = 8;

  // Ideal cell response {inv_y, nand_y} for stimulus vector {b, a}.
  function automatic logic [1:0] exp_resp(input logic [1:0] vec);
    return {~vec[0], ~(vec[0] & vec[1])};
  endfunction

endpackage

// File: rtl/skullfet_sync2.sv
// Two-flop synchronizer for one asynchronous cell output bit.
module skullfet_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/skullfet_test_sequencer.sv
// Walks an inverter and a NAND cell through all 4 input vectors for N passes and counts mismatches.
// Optional first-failure log enabled by defining SKULLFET_SEQ_ERRLOG_EN.
module skullfet_test_sequencer
  import skullfet_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int LOOP_W        = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [LOOP_W-1:0] loops_i,
  output logic              inv_a_o,
  output logic              nand_a_o,
  output logic              nand_b_o,
  input  logic              inv_y_i,
  input  logic              nand_y_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
`ifdef SKULLFET_SEQ_ERRLOG_EN
  output logic              first_fail_vld_o,
  output logic [1:0]        first_fail_vec_o,
  output logic [1:0]        first_fail_obs_o,
`endif
  output logic [ERR_W-1:0]  err_cnt_o
);

  state_t            state_q, state_n;
  logic [1:0]        vec_q;
  logic [LOOP_W-1:0] loop_q, loops_q;
  logic [7:0]        settle_q;
  logic              inv_s, nand_s;
  logic              mismatch, last;

  skullfet_sync2 u_sync_inv  (.clk(wb_clk_i), .rst(wb_rst_i), .d(inv_y_i),  .q(inv_s));
  skullfet_sync2 u_sync_nand (.clk(wb_clk_i), .rst(wb_rst_i), .d(nand_y_i), .q(nand_s));

  assign mismatch = ({inv_s, nand_s} != exp_resp(vec_q));
  assign last     = (vec_q == 2'(NUM_VECTORS - 1)) && (loop_q == loops_q - 1'b1);
  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (start_i) state_n = DRIVE;
      DRIVE:   state_n = SETTLE;
      SETTLE:  if (settle_q == 8'd0) state_n = CHECK;
      CHECK:   state_n = last ? DONE : DRIVE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      loop_q    <= '0;
      loops_q   <= '0;
      settle_q  <= '0;
      err_cnt_o <= '0;
      pass_o    <= 1'b0;
      inv_a_o   <= 1'b0;
      nand_a_o  <= 1'b0;
      nand_b_o  <= 1'b0;
    end else begin
      state_q <= state_n;
      case (state_q)
        IDLE: if (start_i) begin
          vec_q     <= '0;
          loop_q    <= '0;
          err_cnt_o <= '0;
          pass_o    <= 1'b0;
          loops_q   <= (loops_i == '0) ? LOOP_W'(1) : loops_i;
        end
        DRIVE: begin
          inv_a_o  <= vec_q[0];
          nand_a_o <= vec_q[0];
          nand_b_o <= vec_q[1];
          settle_q <= 8'(SETTLE_CYCLES - 1);
        end
        SETTLE: if (settle_q != 8'd0) settle_q <= settle_q - 1'b1;
        CHECK: begin
          if (mismatch && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
          if (last) begin
            // pass is resolved on entry to DONE so it is valid alongside done_o
            pass_o   <= (err_cnt_o == '0) && !mismatch;
            inv_a_o  <= 1'b0;
            nand_a_o <= 1'b0;
            nand_b_o <= 1'b0;
          end else begin
            vec_q <= vec_q + 1'b1;
            if (vec_q == 2'(NUM_VECTORS - 1)) loop_q <= loop_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SKULLFET_SEQ_ERRLOG_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      first_fail_vld_o <= 1'b0;
      first_fail_vec_o <= '0;
      first_fail_obs_o <= '0;
    end else if (state_q == IDLE && start_i) begin
      first_fail_vld_o <= 1'b0;
      first_fail_vec_o <= '0;
      first_fail_obs_o <= '0;
    end else if (state_q == CHECK && mismatch && !first_fail_vld_o) begin
      first_fail_vld_o <= 1'b1;
      first_fail_vec_o <= vec_q;
      first_fail_obs_o <= {inv_s, nand_s};
    end
  end
`endif

endmodule

// File: tb/tb_skullfet_test_sequencer.sv
// Directed table-driven bench for skullfet_test_sequencer with a behavioural cell model.
module tb_skullfet_test_sequencer;

  localparam int S     = 8;
  localparam int LIMIT = 10000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] loops = '0;
  logic       inv_a, nand_a, nand_b;
  logic       inv_y, nand_y;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
`ifdef SKULLFET_SEQ_ERRLOG_EN
  logic       ff_vld;
  logic [1:0] ff_vec, ff_obs;
`endif

  // cell fault modes: 0 ideal, 1 stuck-at-0, 2 stuck-at-1
  int inv_mode  = 0;
  int nand_mode = 0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    inv_y  = ~inv_a;
    nand_y = ~(nand_a & nand_b);
    if (inv_mode == 1) inv_y = 1'b0;
    else if (inv_mode == 2) inv_y = 1'b1;
    if (nand_mode == 1) nand_y = 1'b0;
    else if (nand_mode == 2) nand_y = 1'b1;
  end

  skullfet_test_sequencer #(.SETTLE_CYCLES(S), .LOOP_W(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .start_i  (start),
    .loops_i  (loops),
    .inv_a_o  (inv_a),
    .nand_a_o (nand_a),
    .nand_b_o (nand_b),
    .inv_y_i  (inv_y),
    .nand_y_i (nand_y),
    .busy_o   (busy),
    .done_o   (done),
    .pass_o   (pass),
`ifdef SKULLFET_SEQ_ERRLOG_EN
    .first_fail_vld_o (ff_vld),
    .first_fail_vec_o (ff_vec),
    .first_fail_obs_o (ff_obs),
`endif
    .err_cnt_o (err_cnt)
  );

  typedef struct {
    int loops;
    int inv_mode;
    int nand_mode;
    int inj;       // cycle at which a stray start is pulsed, -1 for none
    int exp_err;
    int exp_pass;
    int exp_lat;
  } row_t;

  row_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start a run and count edges (accepting edge = 1) until done_o is seen.
  task automatic run(input int nloops, input int inj, output int lat);
    logic [1:0] v;
    @(negedge clk);
    start = 1'b1;
    loops = nloops[7:0];
    lat   = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        chk("busy_after_accept", int'(busy), 1);
        chk("err_clear_on_accept", int'(err_cnt), 0);
        chk("pass_clear_on_accept", int'(pass), 0);
      end
      if (lat == inj) begin
        start = 1'b1;
        loops = 8'd5;
      end else if (lat == inj + 1) begin
        start = 1'b0;
      end
      if (done) break;
      if (lat >= 2 && (lat - 2) % (S + 2) == 0) begin
        v = 2'(((lat - 2) / (S + 2)) % 4);
        chk("stim_vec", int'({inv_a, nand_a, nand_b}), int'({v[0], v[0], v[1]}));
      end
      if (lat >= LIMIT) begin
        chk("done_timeout", 0, 1);
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int seen;

    tbl[0] = '{loops: 1,   inv_mode: 0, nand_mode: 0, inj: -1, exp_err: 0,   exp_pass: 1, exp_lat: 41};
    tbl[1] = '{loops: 2,   inv_mode: 1, nand_mode: 0, inj: -1, exp_err: 4,   exp_pass: 0, exp_lat: 81};
    tbl[2] = '{loops: 100, inv_mode: 1, nand_mode: 2, inj: -1, exp_err: 255, exp_pass: 0, exp_lat: 4001};
    tbl[3] = '{loops: 0,   inv_mode: 0, nand_mode: 0, inj: -1, exp_err: 0,   exp_pass: 1, exp_lat: 41};
    tbl[4] = '{loops: 3,   inv_mode: 0, nand_mode: 1, inj: -1, exp_err: 9,   exp_pass: 0, exp_lat: 121};
    tbl[5] = '{loops: 1,   inv_mode: 2, nand_mode: 0, inj: 10, exp_err: 2,   exp_pass: 0, exp_lat: 41};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_stim", int'({inv_a, nand_a, nand_b}), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      inv_mode  = tbl[i].inv_mode;
      nand_mode = tbl[i].nand_mode;
      run(tbl[i].loops, tbl[i].inj, lat);
      chk($sformatf("latency[%0d]", i), lat, tbl[i].exp_lat);
      chk($sformatf("err[%0d]", i), int'(err_cnt), tbl[i].exp_err);
      chk($sformatf("pass[%0d]", i), int'(pass), tbl[i].exp_pass);
      chk($sformatf("done_stim[%0d]", i), int'({inv_a, nand_a, nand_b}), 0);
      // start asserted while in DONE must not launch a run
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk($sformatf("done_start_busy[%0d]", i), int'(busy), 0);
      chk($sformatf("done_pulse_width[%0d]", i), int'(done), 0);
      chk($sformatf("pass_hold[%0d]", i), int'(pass), tbl[i].exp_pass);
      repeat (2) @(posedge clk);
    end

`ifdef SKULLFET_SEQ_ERRLOG_EN
    inv_mode  = 0;
    nand_mode = 2;
    run(1, -1, lat);
    chk("ff_vld", int'(ff_vld), 1);
    chk("ff_vec", int'(ff_vec), 3);
    chk("ff_obs", int'(ff_obs), 1);
    nand_mode = 0;
    run(1, -1, lat);
    chk("ff_vld_clean_run", int'(ff_vld), 0);
    repeat (2) @(posedge clk);
`endif

    // mid-run reset abort: vector 0 already failed by cycle 20
    inv_mode  = 1;
    nand_mode = 0;
    @(negedge clk);
    start = 1'b1;
    loops = 8'd1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("abort_pre_err", int'(err_cnt), 1);
    chk("abort_pre_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_stim", int'({inv_a, nand_a, nand_b}), 0);
    chk("abort_err", int'(err_cnt), 0);
    chk("abort_pass", int'(pass), 0);
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("abort_no_done", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/skullfet_test_sequencer.md
SKULLFET_TEST_SEQUENCER -- requirements
Module: skullfet_test_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 8: cycles between stimulus change and sampling; legal range 3..255.
REQ-002 Parameter LOOP_W, default 8: width of the pass-count input.
REQ-003 wb_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 start_i  in  1  run request, sampled only in IDLE.
REQ-006 loops_i  in  LOOP_W  number of passes over the 4-vector set, sampled with start_i.
REQ-007 inv_a_o  out  1  drives the inverter cell A input.
REQ-008 nand_a_o, nand_b_o  out  1 each  drive the NAND cell A and B inputs.
REQ-009 inv_y_i, nand_y_i  in  1 each  cell outputs, asynchronous to wb_clk_i.
REQ-010 busy_o  out  1  high in every state except IDLE.
REQ-011 done_o  out  1  one-cycle pulse at end of run.
REQ-012 pass_o  out  1  high when the last run had zero mismatches; holds until the next accepted start.
REQ-013 err_cnt_o  out  8  mismatch count of the current or last run, saturating.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-015 IDLE with start_i=1 -> DRIVE: vec=0, loop=0, err_cnt=0, pass_o=0, latch loops_i; a latched value of 0 is treated as 1.
REQ-016 DRIVE (1 cycle): registered outputs inv_a_o=vec[0], nand_a_o=vec[0], nand_b_o=vec[1]; then -> SETTLE.
REQ-017 SETTLE: lasts exactly SETTLE_CYCLES cycles, counted by a down-counter; then -> CHECK.
REQ-018 CHECK (1 cycle): compare the synchronized outputs against expected inv_y=~vec[0] and nand_y=~(vec[0]&vec[1]).
REQ-019 CHECK: add 1 to err_cnt if either output mismatches (at most +1 per vector); hold at 255 on saturation.
REQ-020 CHECK: if vec==3 and loop==latched_loops-1 -> DONE; otherwise advance vec (3 wraps to 0, incrementing loop) and go to DRIVE.
REQ-021 DONE (1 cycle): done_o=1, pass_o=(err_cnt==0); then -> IDLE.
REQ-022 Latency: done_o high exactly 4*N*(SETTLE_CYCLES+2)+1 cycles after the cycle in which start_i was accepted, where N is the effective loop count.
REQ-023 start_i outside IDLE, including in DONE, SHALL be ignored with no effect.
REQ-024 In IDLE, DONE and reset, the stimulus outputs SHALL be 0.
REQ-025 inv_y_i and nand_y_i SHALL pass through 2-flop synchronizers before comparison.

Reset
REQ-026 wb_rst_i=1 at any edge, including mid-run, SHALL force: state IDLE, all outputs 0, err_cnt 0, counters 0, synchronizer flops 0; no done_o is produced for the aborted run.

Configuration
REQ-027 Macro SKULLFET_SEQ_ERRLOG_EN defined: add outputs first_fail_vld_o (1), first_fail_vec_o (2) and first_fail_obs_o (2, {inv_y,nand_y}).
REQ-028 With SKULLFET_SEQ_ERRLOG_EN: capture the first mismatch of a run; clear on accepted start and on reset.
REQ-029 SKULLFET_SEQ_ERRLOG_EN undefined: these ports and registers are absent; all other behaviour is identical.

Structure
REQ-030 Package skullfet_seq_pkg SHALL hold: state enum, NUM_VECTORS=4, ERR_W=8, and the expected-response function.
REQ-031 The synchronizer SHALL be a separate sub-module skullfet_sync2 (1-bit, 2 flops, synchronous reset), instantiated twice.

Verification
REQ-032 Ideal cell model, loops_i=1, SETTLE_CYCLES=8, start pulsed at cycle 0 -> done_o at cycle 41, pass_o=1, err_cnt_o=0.
REQ-033 inv_y_i stuck 0, loops_i=2 -> err_cnt_o=4 (vectors 0 and 2 in each pass), pass_o=0.
REQ-034 inv_y_i stuck 0 and nand_y_i stuck 1, loops_i=100 -> 3 mismatches per pass, err_cnt_o saturates at 255, pass_o=0.
REQ-035 start_i pulsed at cycle 10 during a run -> no effect on timing; wb_rst_i high at cycle 20 -> from cycle 21 busy_o=0 and stimulus outputs 0, and no done_o follows.
REQ-036 loops_i=0 -> behaves as loops_i=1, done_o at cycle 41.
REQ-037 SKULLFET_SEQ_ERRLOG_EN defined, nand_y_i stuck 1 -> first_fail_vld_o=1, first_fail_vec_o=3, first_fail_obs_o=2'b01.
